// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-side state encoding and the
// frame-format defaults used by both the receive and transmit paths.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    // Width of an index/counter that must hold 0 .. n-1 (at least 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver result bundle: received word, its valid pulse, the framing
// error pulse and the busy flag. master = receiver, slave = consumer.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);

    logic [DATA_BITS-1:0] data_o;
    logic                 data_valid_o;
    logic                 framing_err_o;
    logic                 busy_o;

    modport master (
        output data_o,
        output data_valid_o,
        output framing_err_o,
        output busy_o
    );

    modport slave (
        input data_o,
        input data_valid_o,
        input framing_err_o,
        input busy_o
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports: clk_i, reset_i (sync, active-high), d_i (async), q_o (synced).
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing, mid-bit sampling, LSB first.
// Ports: clk_i, reset_i (sync, active-high), rx_i (async serial line),
// bus (uart_rx_if.master: data_o, data_valid_o, framing_err_o, busy_o).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic      clk_i,
    input  logic      reset_i,
    input  logic      rx_i,
    uart_rx_if.master bus
);

    localparam int CW = idx_width(CLKS_PER_BIT);
    localparam int IW = idx_width(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    rx_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic [1:0]           fill_q;
    logic                 armed_q;
    logic                 rx_s;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (rx_i),
        .q_o     (rx_s)
    );

    // The synchronizer resets high, so its output only reflects the real
    // line once both flops have been refilled (fill_q[1]). The receiver
    // arms only after it has then seen the line high, so a line that is
    // already low when reset is released does not look like a start bit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            fill_q  <= {fill_q[0], 1'b1};
            if (fill_q[1] && rx_s) begin
                armed_q <= 1'b1;
            end

            unique case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (armed_q && !rx_s) begin
                        state_q <= RX_START;
                    end
                end

                RX_START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= RX_IDLE;
                        end else begin
                            state_q <= RX_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                RX_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                RX_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shreg_q;
                            valid_q <= 1'b1;
                            state_q <= RX_IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= RX_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                RX_BREAK: begin
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= RX_IDLE;
                    end
                end

                default: begin
                    state_q <= RX_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.data_o        = data_q;
    assign bus.data_valid_o  = valid_q;
    assign bus.framing_err_o = ferr_q;
    assign bus.busy_o        = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of frames plus hand-built sequences
// for glitch, back-to-back, mid-frame reset and low-line-after-reset.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    logic prev_pulse = 1'b0;
    logic [DB-1:0] data_log[$];

    always #5 clk = ~clk;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .rx_i    (rx),
        .bus     (bus)
    );

    typedef struct {
        string         name;
        logic [DB-1:0] data;
        logic          stop;
        logic [DB-1:0] exp_data;
        int            exp_valid;
        int            exp_ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Pulse monitor: counts pulses, logs received words and checks that
    // the two pulses never overlap and never last two cycles.
    always @(negedge clk) begin
        if (bus.data_valid_o) begin
            valid_cnt++;
            data_log.push_back(bus.data_o);
        end
        if (bus.framing_err_o) begin
            ferr_cnt++;
        end
        if (bus.data_valid_o || bus.framing_err_o) begin
            checks++;
            if ((bus.data_valid_o && bus.framing_err_o) || prev_pulse) begin
                errors++;
                $display("FAIL pulse_shape actual=%b%b prev=%b required=single",
                         bus.data_valid_o, bus.framing_err_o, prev_pulse);
            end
        end
        prev_pulse = bus.data_valid_o | bus.framing_err_o;
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) begin
            send_bit(d[i]);
        end
        send_bit(stop);
    endtask

    initial begin
        int v0;
        int f0;
        int n0;

        vecs[0] = '{"a5_good", 8'hA5, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{"3c_badstop", 8'h3C, 1'b0, 8'hA5, 0, 1};
        vecs[2] = '{"00_good", 8'h00, 1'b1, 8'h00, 1, 0};
        vecs[3] = '{"ff_good", 8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[4] = '{"01_good", 8'h01, 1'b1, 8'h01, 1, 0};
        vecs[5] = '{"80_good", 8'h80, 1'b1, 8'h80, 1, 0};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(bus.data_o), 32'h0);
        check("rst_valid", 32'(bus.data_valid_o), 32'h0);
        check("rst_ferr", 32'(bus.framing_err_o), 32'h0);
        check("rst_busy", 32'(bus.busy_o), 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop);
            if (!vecs[i].stop) begin
                repeat (40) @(negedge clk);
                check({vecs[i].name, "_busy_break"}, 32'(bus.busy_o), 32'h1);
                rx = 1'b1;
            end
            repeat (6) @(negedge clk);
            check({vecs[i].name, "_busy"}, 32'(bus.busy_o), 32'h0);
            check({vecs[i].name, "_valid"}, 32'(valid_cnt - v0),
                  32'(vecs[i].exp_valid));
            check({vecs[i].name, "_ferr"}, 32'(ferr_cnt - f0),
                  32'(vecs[i].exp_ferr));
            check({vecs[i].name, "_data"}, 32'(bus.data_o),
                  32'(vecs[i].exp_data));
        end

        // Short low glitch on an idle line.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_hi", 32'(bus.busy_o), 32'h1);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy", 32'(bus.busy_o), 32'h0);
        check("glitch_valid", 32'(valid_cnt - v0), 32'h0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'h0);
        check("glitch_data", 32'(bus.data_o), 32'h80);

        // Back-to-back frames with no idle bit between them.
        v0 = valid_cnt;
        n0 = data_log.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (6) @(negedge clk);
        check("b2b_valid", 32'(valid_cnt - v0), 32'h2);
        if (data_log.size() >= n0 + 2) begin
            check("b2b_first", 32'(data_log[n0]), 32'h00);
            check("b2b_second", 32'(data_log[n0+1]), 32'hFF);
        end else begin
            check("b2b_logged", 32'(data_log.size() - n0), 32'h2);
        end

        // Reset after three data bits of 0x81 (1,0,0), line left low.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        check("mid_busy_pre", 32'(bus.busy_o), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_data", 32'(bus.data_o), 32'h0);
        check("mid_rst_valid", 32'(bus.data_valid_o), 32'h0);
        check("mid_rst_ferr", 32'(bus.framing_err_o), 32'h0);
        check("mid_rst_busy", 32'(bus.busy_o), 32'h0);
        rst = 1'b0;

        // Line still low after reset: must not be taken as a start bit.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        repeat (40) @(negedge clk);
        check("lowrel_busy", 32'(bus.busy_o), 32'h0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("lowrel_ferr", 32'(ferr_cnt - f0), 32'h0);
        check("lowrel_valid", 32'(valid_cnt - v0), 32'h0);

        send_frame(8'h5A, 1'b1);
        repeat (6) @(negedge clk);
        check("post_rst_valid", 32'(valid_cnt - v0), 32'h1);
        check("post_rst_data", 32'(bus.data_o), 32'h5A);
        check("post_rst_busy", 32'(bus.busy_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, clocks per serial bit period (minimum 4).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, data bits per frame.
REQ-003 Port: clk_i  input  1  single clock; all logic on posedge.
REQ-004 Port: reset_i  input  1  reset, synchronous and active-high.
REQ-005 Port: rx_i  input  1  asynchronous serial line; idles high.
REQ-006 Port: data_o  output  DATA_BITS  last correctly received byte; held until the next good frame.
REQ-007 Port: data_valid_o  output  1  single-cycle pulse: data_o updated.
REQ-008 Port: framing_err_o  output  1  single-cycle pulse: stop bit sampled low.
REQ-009 Port: busy_o  output  1  high whenever state is not IDLE.

Function
REQ-010 rx_i SHALL pass through a 2-flop synchronizer; all decisions use the synchronized line rx_s (2-cycle latency).
REQ-011 States SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-012 IDLE: when rx_s = 0, clear the bit-period counter and go to START.
REQ-013 START: at counter = CLKS_PER_BIT/2 - 1 (mid start bit), if rx_s = 1 (glitch), return to IDLE; otherwise clear the counter and go to DATA.
REQ-014 DATA: sample rx_s when counter = CLKS_PER_BIT - 1 (mid bit), shift it into the shift register LSB-first, clear the counter, and increment the bit index.
REQ-015 DATA: after bit index DATA_BITS-1 is sampled, go to STOP.
REQ-016 STOP: at counter = CLKS_PER_BIT - 1, if rx_s = 1, load data_o from the shift register, pulse data_valid_o for one cycle, and go to IDLE.
REQ-017 STOP: at counter = CLKS_PER_BIT - 1, if rx_s = 0, pulse framing_err_o for one cycle, leave data_o unchanged, and go to BREAK.
REQ-018 BREAK: stay until rx_s = 1, then go to IDLE; no further error pulses.
REQ-019 data_valid_o and framing_err_o SHALL be registered, SHALL be mutually exclusive, and SHALL never be high for two consecutive cycles.
REQ-020 A start edge arriving in the cycle that IDLE is re-entered from STOP SHALL be detected on the next cycle, so back-to-back frames with zero idle bits are received.
REQ-021 Counter width SHALL be $clog2(CLKS_PER_BIT); it SHALL never wrap past CLKS_PER_BIT - 1.

Reset
REQ-022 reset_i SHALL force the following on the next posedge, including mid-frame: state IDLE, counters 0, shift register 0, data_o 0, data_valid_o 0, framing_err_o 0, busy_o 0, synchronizer flops 1.
REQ-023 After reset is released, the block SHALL ignore an rx_i held low until a high-to-low transition is seen on rx_s.

Structure
REQ-024 Package uart_pkg SHALL hold the rx state enum, DATA_BITS default, and CLKS_PER_BIT default, shared with the transmit side.
REQ-025 The synchronizer SHALL be a separate sub-module, uart_sync2.
REQ-026 The FSM, counters, and shift register SHALL be in uart_rx; the RTL SHALL contain no latches and no multi-clock logic.

Verification (CLKS_PER_BIT = 16, DATA_BITS = 8)
REQ-027 Frame 0xA5 with a good stop bit -> data_o = 0xA5, data_valid_o high exactly 1 cycle, framing_err_o stays 0, busy_o returns low.
REQ-028 rx_i low for 4 cycles, then high -> return to IDLE, no pulses, data_o unchanged.
REQ-029 Frame 0x3C with stop bit low, line held low for 40 cycles -> one framing_err_o pulse, no data_valid_o, busy_o high until rx_s rises.
REQ-030 Frames 0x00 then 0xFF back-to-back with no idle bit -> two data_valid_o pulses, carrying 0x00 then 0xFF.
REQ-031 Reset asserted after 3 data bits of 0x81 -> all outputs 0 next cycle; a following clean frame 0x5A yields data_o = 0x5A.
